// File: rtl/adder_char_pkg.sv
// adder_char_pkg
//   Shared definitions for the adder energy-characterization traffic source:
//   default sizing constants, the injector FSM state type and the strided
//   Johnson (twisted-ring) step function used to generate operand patterns.
package adder_char_pkg;

    localparam int unsigned N_DEF       = 25;
    localparam int unsigned PAYLOAD_DEF = 20;
    localparam int unsigned GAP_DEF     = 7;
    localparam int unsigned NUM_PKT_DEF = 10;
    localparam int unsigned STRIDE_DEF  = 23;

    // Widest pattern word the step function handles (operand width up to 32).
    localparam int unsigned STEP_MAX_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } inj_state_e;

    // step(x) = {x[w-stride-1:0], ~x[w-1:w-stride]} on the low w bits.
    // Every call flips exactly 'stride' bits of the w-bit word. Bits at and
    // above w are returned as zero.
    function automatic logic [STEP_MAX_W-1:0] johnson_step(
        input logic [STEP_MAX_W-1:0] x,
        input int unsigned           w,
        input int unsigned           stride
    );
        logic [STEP_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < STEP_MAX_W; i++) begin
            if (i < stride) begin
                r[i] = ~x[w - stride + i];
            end else if (i < w) begin
                r[i] = x[i - stride];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_stride_gen.sv
// johnson_stride_gen
//   Pattern register for the flit injector. Holds a W-bit word that either
//   holds, reloads to step(0), or advances by one strided Johnson step.
// Ports:
//   clk              clock
//   rst              asynchronous active-high reset (pattern -> 0)
//   load_zero_step_i load step(0) (takes priority over advance_i)
//   advance_i        replace pattern with step(pattern)
//   pattern_o        current pattern word
module johnson_stride_gen
    import adder_char_pkg::*;
#(
    parameter int unsigned W      = 2 * N_DEF,
    parameter int unsigned STRIDE = STRIDE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_zero_step_i,
    input  logic         advance_i,
    output logic [W-1:0] pattern_o
);

    logic [W-1:0]          pattern_q;
    logic [W-1:0]          pattern_d;
    logic [STEP_MAX_W-1:0] step_in;

    always_comb begin
        step_in   = load_zero_step_i ? '0 : STEP_MAX_W'(pattern_q);
        pattern_d = pattern_q;
        if (load_zero_step_i || advance_i) begin
            pattern_d = W'(johnson_step(step_in, W, STRIDE));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= '0;
        end else begin
            pattern_q <= pattern_d;
        end
    end

    assign pattern_o = pattern_q;

endmodule

// File: rtl/adder_flit_injector.sv
// adder_flit_injector
//   Packet/flit traffic source feeding the two operand buses of the
//   characterization adder. A run emits NUM_PKT packets of PAYLOAD flits with
//   GAP idle cycles between packets; each new flit inside a packet toggles
//   exactly STRIDE of the 2N operand bits, and every packet restarts at step(0).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      run request, only honoured in IDLE
//   out_ready  downstream accepts the current flit
//   valid_out  input1/input2 carry a valid flit
//   input1     pattern[N-1:0]
//   input2     pattern[2N-1:N]
//   flit_cnt   flits transferred in the current packet
//   pkt_cnt    packets completed in this run
//   busy       high while sending or in a gap
//   done       one-cycle pulse at the end of a run
module adder_flit_injector
    import adder_char_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned PAYLOAD = PAYLOAD_DEF,
    parameter int unsigned GAP     = GAP_DEF,
    parameter int unsigned NUM_PKT = NUM_PKT_DEF,
    parameter int unsigned STRIDE  = STRIDE_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               out_ready,
    output logic                               valid_out,
    output logic [N-1:0]                       input1,
    output logic [N-1:0]                       input2,
    output logic [$clog2(PAYLOAD+1)-1:0]       flit_cnt,
    output logic [$clog2(NUM_PKT+1)-1:0]       pkt_cnt,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned FW = $clog2(PAYLOAD + 1);
    localparam int unsigned PW = $clog2(NUM_PKT + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [FW-1:0] LAST_FLIT = FW'(PAYLOAD - 1);
    localparam logic [PW-1:0] LAST_PKT  = PW'(NUM_PKT - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((GAP > 0) ? GAP - 1 : 0);

    inj_state_e    state_q, state_d;
    logic [FW-1:0] flit_q, flit_d;
    logic [PW-1:0] pkt_q, pkt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_zero_step;
    logic          advance;
    logic [W-1:0]  pattern;

    johnson_stride_gen #(
        .W      (W),
        .STRIDE (STRIDE)
    ) u_gen (
        .clk              (clk),
        .rst              (rst),
        .load_zero_step_i (load_zero_step),
        .advance_i        (advance),
        .pattern_o        (pattern)
    );

    always_comb begin
        state_d        = state_q;
        flit_d         = flit_q;
        pkt_d          = pkt_q;
        gap_d          = gap_q;
        load_zero_step = 1'b0;
        advance        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_zero_step = 1'b1;
                    flit_d         = '0;
                    pkt_d          = '0;
                    state_d        = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (flit_q == LAST_FLIT) begin
                        // Last flit leaves the pattern untouched so the gap
                        // (and the idle time after a run) has no toggling.
                        flit_d = '0;
                        pkt_d  = pkt_q + PW'(1);
                        if (pkt_q == LAST_PKT) begin
                            state_d = ST_DONE;
                        end else if (GAP == 0) begin
                            load_zero_step = 1'b1;
                        end else begin
                            gap_d   = '0;
                            state_d = ST_GAP;
                        end
                    end else begin
                        flit_d  = flit_q + FW'(1);
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == LAST_GAP) begin
                    load_zero_step = 1'b1;
                    state_d        = ST_SEND;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so that none of
        // them has a combinational path from out_ready.
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flit_q  <= '0;
            pkt_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            pkt_q   <= pkt_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign valid_out = valid_q;
    assign input1    = pattern[N-1:0];
    assign input2    = pattern[W-1:N];
    assign flit_cnt  = flit_q;
    assign pkt_cnt   = pkt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_adder_flit_injector.sv
module tb_adder_flit_injector;

    // DUT A: defaults (N=25, PAYLOAD=20, GAP=7, NUM_PKT=10, STRIDE=23)
    localparam int W_A = 50;
    localparam int S_A = 23;
    localparam int P_A = 20;
    localparam int G_A = 7;
    localparam int K_A = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_a = 1'b0, rdy_a = 1'b1;
    logic        valid_a, busy_a, done_a;
    logic [24:0] in1_a, in2_a;
    logic [4:0]  flit_a;
    logic [3:0]  pkt_a;

    logic        start_b = 1'b0;
    logic        valid_b, busy_b, done_b;
    logic [24:0] in1_b, in2_b;
    logic [2:0]  flit_b;
    logic [1:0]  pkt_b;

    logic        start_c = 1'b0;
    logic        valid_c, busy_c, done_c;
    logic [24:0] in1_c, in2_c;
    logic [4:0]  flit_c;
    logic [3:0]  pkt_c;

    adder_flit_injector u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .out_ready(rdy_a),
        .valid_out(valid_a), .input1(in1_a), .input2(in2_a),
        .flit_cnt(flit_a), .pkt_cnt(pkt_a), .busy(busy_a), .done(done_a)
    );

    adder_flit_injector #(.PAYLOAD(4), .GAP(0), .NUM_PKT(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .out_ready(1'b1),
        .valid_out(valid_b), .input1(in1_b), .input2(in2_b),
        .flit_cnt(flit_b), .pkt_cnt(pkt_b), .busy(busy_b), .done(done_b)
    );

    adder_flit_injector #(.STRIDE(50)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .out_ready(1'b1),
        .valid_out(valid_c), .input1(in1_c), .input2(in2_c),
        .flit_cnt(flit_c), .pkt_cnt(pkt_c), .busy(busy_c), .done(done_c)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_cyc = -1;
    bit done_flag = 1'b0;

    // Behavioural model of DUT A: expected outputs for the current cycle.
    bit          m_active, m_done, m_valid, m_busy;
    int          m_xfer, m_gap_left, m_flit, m_pkt;
    logic [63:0] m_pat;

    function automatic logic [63:0] tb_step(input logic [63:0] x, input int w, input int s);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((x << s) | ((~x & mask) >> (w - s))) & mask;
    endfunction

    function automatic logic [63:0] stepn(input int k, input int w, input int s);
        logic [63:0] x;
        x = '0;
        for (int i = 0; i < k; i++) x = tb_step(x, w, s);
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_valid = 0; m_busy = 0;
        m_xfer = 0; m_gap_left = 0; m_flit = 0; m_pkt = 0; m_pat = '0;
    endtask

    task automatic model_advance(input bit st, input bit rdy);
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_xfer = 0; m_valid = 1; m_busy = 1;
                m_flit = 0; m_pkt = 0; m_pat = stepn(1, W_A, S_A);
            end
        end else if (m_valid) begin
            if (rdy) begin
                m_xfer++;
                if (m_xfer % P_A == 0) begin
                    m_flit = 0;
                    m_pkt  = m_xfer / P_A;
                    m_valid = 0;
                    if (m_xfer == P_A * K_A) begin
                        m_active = 0; m_done = 1; m_busy = 0;
                    end else begin
                        m_gap_left = G_A;
                    end
                end else begin
                    m_flit = m_xfer % P_A;
                    m_pat  = stepn(m_flit + 1, W_A, S_A);
                end
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                m_valid = 1;
                m_pat   = stepn(1, W_A, S_A);
            end
        end
    endtask

    task automatic compare_a();
        chk("a_valid", valid_a, m_valid);
        chk("a_busy",  busy_a,  m_busy);
        chk("a_done",  done_a,  m_done);
        chk("a_data",  {in2_a, in1_a}, m_pat);
        chk("a_flit",  flit_a,  m_flit);
        chk("a_pkt",   pkt_a,   m_pkt);
    endtask

    // Called at a negedge: check DUT A, drive inputs for the next edge.
    task automatic step_cycle(input bit st, input bit rdy);
        compare_a();
        if (done_a === 1'b1) begin
            done_flag = 1'b1;
            done_cyc  = cyc;
        end
        start_a = st;
        rdy_a   = rdy;
        model_advance(st, rdy);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, stalls, nflit, done_at;
        bit          ok, gap_seen, have_prev, rdy;
        logic [63:0] flits[16];
        logic [63:0] cur, prev, f0;

        model_reset();
        #3;
        chk("rst_valid", valid_a, 0);
        chk("rst_data",  {in2_a, in1_a}, 0);
        chk("rst_cnts",  {busy_a, done_a, flit_a, pkt_a}, 0);
        chk("rst_b",     {valid_b, busy_b, done_b, in1_b, in2_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step_cycle(0, 1);

        // Run A: full run with out_ready=1
        t0 = cyc; done_flag = 0; have_prev = 0; f0 = '0; prev = '0;
        step_cycle(1, 1);
        for (int i = 0; i < 400 && !done_flag; i++) begin
            cur = {in2_a, in1_a};
            if (cyc == t0 + 1) begin
                chk("flit0_in1", in1_a, 25'h07FFFFF);
                chk("flit0_in2", in2_a, 25'h0000000);
                f0 = cur;
            end
            if (cyc == t0 + 2) begin
                chk("flit1_in1", in1_a, 25'h1FFFFFF);
                chk("flit1_in2", in2_a, 25'h01FFFFF);
            end
            if (cyc == t0 + 28) chk("pkt1_flit0", cur, f0);
            if (valid_a) begin
                if (have_prev && flit_a != 0) chk("popcount23", $countones(cur ^ prev), 23);
                prev = cur; have_prev = 1;
            end
            step_cycle(0, 1);
        end
        chk("runA_done_seen", done_flag, 1);
        chk("runA_done_cycle", done_cyc, t0 + 264);
        step_cycle(0, 1);
        chk("runA_after", {busy_a, done_a, pkt_a}, {1'b0, 1'b0, 4'd10});

        // Run B: 5-cycle stall on flit 3 of packet 0
        repeat (3) step_cycle(0, 1);
        t0 = cyc; done_flag = 0; stalls = 0;
        step_cycle(1, 1);
        for (int i = 0; i < 400 && !done_flag; i++) begin
            rdy = !(valid_a && flit_a == 3 && pkt_a == 0 && stalls < 5);
            if (!rdy) stalls++;
            step_cycle(0, rdy);
        end
        chk("runB_stalls", stalls, 5);
        chk("runB_done_cycle", done_cyc, t0 + 269);

        // Run C: random start pulses and random backpressure
        for (int i = 0; i < 1500; i++)
            step_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (!m_active && !m_done) ok = 1;
            else step_cycle(0, 1);
        end
        chk("runC_drained", ok, 1);

        // Run D: GAP=0, PAYLOAD=4, NUM_PKT=2
        start_b = 1'b1;
        step_cycle(0, 1);
        start_b = 1'b0;
        nflit = 0; done_at = -1; gap_seen = 0;
        for (int i = 1; i <= 12; i++) begin
            if (valid_b && nflit < 16) begin
                flits[nflit] = {14'd0, in2_b, in1_b};
                nflit++;
                if (i != nflit) gap_seen = 1;
            end
            if (done_b) done_at = i;
            step_cycle(0, 1);
        end
        chk("g0_valid_cycles", nflit, 8);
        chk("g0_contiguous", gap_seen, 0);
        chk("g0_done_cycle", done_at, 9);
        chk("g0_flit4_eq_flit0", flits[4], flits[0]);
        for (int k = 0; k < 8 && k < nflit; k++)
            chk("g0_flit_data", flits[k], stepn(k % 4 + 1, W_A, S_A));

        // Run E: STRIDE = W = 50
        start_c = 1'b1;
        step_cycle(0, 1);
        start_c = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("s50_valid", valid_c, 1);
            chk("s50_in1", in1_c, (i % 2 == 1) ? 25'h1FFFFFF : 25'h0);
            chk("s50_in2", in2_c, (i % 2 == 1) ? 25'h1FFFFFF : 25'h0);
            step_cycle(0, 1);
        end

        // Run F: reset in the middle of the gap after packet 3
        done_flag = 0; ok = 0;
        step_cycle(1, 1);
        for (int i = 0; i < 200 && !ok; i++) begin
            if (pkt_a == 3 && busy_a && !valid_a) ok = 1;
            else step_cycle(0, 1);
        end
        chk("runF_reached_gap", ok, 1);
        repeat (3) step_cycle(0, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", valid_a, 0);
        chk("async_rst_data",  {in2_a, in1_a}, 0);
        chk("async_rst_cnts",  {busy_a, done_a, flit_a, pkt_a}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step_cycle(0, 1);
        chk("runF_no_done", done_flag, 0);
        step_cycle(1, 1);
        chk("restart_in1", in1_a, 25'h07FFFFF);
        chk("restart_pkt", pkt_a, 0);
        for (int i = 0; i < 300; i++) step_cycle(0, $urandom_range(0, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
